pot_weight_encoder: RTL

// - Quantises a signed integer weight to the power-of-two (POT) code consumed by the POT shift multipliers.
// - Code format: weight[WEIGHT_BIT_WIDTH-1] = sign (1 = negative); weight[WEIGHT_BIT_WIDTH-2:0] = exponent e.
// - A code represents the value (sign ? -1 : +1) * 2**e.
// - Sits in the weight-load path, before weight storage.
// - Serial leading-one scan, one bit per cycle, behind valid/ready handshakes on input and output.

---
 rtl/pot_weight_encoder_if.sv | 24 ++
 rtl/pot_weight_encoder.sv | 112 +++++++++++
 2 files changed

// File: rtl/pot_weight_encoder_if.sv
// Valid/ready bundle between a weight source, the POT weight encoder and its consumer.
interface pot_weight_encoder_if #(
  parameter int VALUE_BIT_WIDTH  = 12,
  parameter int WEIGHT_BIT_WIDTH = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [VALUE_BIT_WIDTH-1:0]  value;
  logic                        out_valid;
  logic                        out_ready;
  logic [WEIGHT_BIT_WIDTH-1:0] weight;
  logic                        zero;
  logic                        saturated;

  modport master (
    output in_valid, value, out_ready,
    input  in_ready, out_valid, weight, zero, saturated
  );

  modport slave (
    input  in_valid, value, out_ready,
    output in_ready, out_valid, weight, zero, saturated
  );
endinterface

// File: rtl/pot_weight_encoder.sv
// Serial leading-one scan quantising a signed weight to a {sign, exponent} POT code.
// Define POT_ROUND_NEAREST_EN for round-to-nearest (ties up) instead of truncation.
module pot_weight_encoder #(
  parameter int VALUE_BIT_WIDTH  = 12,
  parameter int WEIGHT_BIT_WIDTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  pot_weight_encoder_if.slave bus
);
  localparam int          N     = VALUE_BIT_WIDTH;
  localparam int          E     = WEIGHT_BIT_WIDTH - 1;
  localparam int unsigned EMAX  = (1 << E) - 1;
  localparam int          IDX_W = $clog2(N);

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [N-1:0]     ONE_N   = N'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                      state_q, state_d;
  logic                        sign_q, sign_d;
  logic [N-1:0]                mag_q, mag_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [WEIGHT_BIT_WIDTH-1:0] weight_q, weight_d;
  logic                        zero_q, zero_d;
  logic                        sat_q, sat_d;
  logic                        out_valid_q;
  int unsigned                 p_val;
  logic [E-1:0]                e_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      idx_q       <= '0;
      weight_q    <= '0;
      zero_q      <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      idx_q       <= idx_d;
      weight_q    <= weight_d;
      zero_q      <= zero_d;
      sat_q       <= sat_d;
      out_valid_q <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    idx_d    = idx_q;
    weight_d = weight_q;
    zero_d   = zero_q;
    sat_d    = sat_q;
    p_val    = '0;
    e_val    = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d  = bus.value[N-1];
          // Unsigned N-bit negate: the most negative input maps to 2**(N-1) cleanly.
          mag_d   = bus.value[N-1] ? (~bus.value + ONE_N) : bus.value;
          idx_d   = IDX_TOP;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (mag_q[idx_q]) begin
          p_val = {{(32-IDX_W){1'b0}}, idx_q};
`ifdef POT_ROUND_NEAREST_EN
          if (idx_q != '0 && mag_q[idx_q - IDX_ONE]) begin
            p_val = p_val + 1;
          end
`endif
          sat_d    = (p_val > EMAX);
          e_val    = sat_d ? '1 : E'(p_val);
          weight_d = {sign_q, e_val};
          zero_d   = 1'b0;
          state_d  = DONE;
        end else if (idx_q == '0) begin
          weight_d = '0;
          zero_d   = 1'b1;
          sat_d    = 1'b0;
          state_d  = DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.weight    = weight_q;
  assign bus.zero      = zero_q;
  assign bus.saturated = sat_q;
endmodule
